// File: rtl/id_ex_pkg.sv
// Shared widths and payload layout for the decode->execute stage.
package id_ex_pkg;

  localparam int XLEN     = 32;   // PC width
  localparam int VLEN     = 128;  // operand / immediate width
  localparam int ALU_OP_W = 4;
  localparam int AI_OP_W  = 3;
  localparam int REG_W    = 5;

  // Everything the execute side needs from decode, moved as one beat.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [VLEN-1:0]     imm;
    logic [VLEN-1:0]     rd1;
    logic [VLEN-1:0]     rd2;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic                regwrite;
    logic                is_ai;
    logic [AI_OP_W-1:0]  ai_opcode;
  } id_ex_payload_t;

  localparam int PAYLOAD_W = $bits(id_ex_payload_t);

  // Source selected for the main (output-facing) entry on a given edge.
  typedef enum logic [1:0] {
    LOAD_NONE = 2'd0,
    LOAD_IN   = 2'd1,
    LOAD_SKID = 2'd2
  } main_load_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// The main entry feeds the output; the skid entry absorbs the one beat that
// can arrive while in_ready is still high after downstream has stalled.
// in_ready depends only on the skid valid flop, never on out_ready.
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid;
  logic         main_valid_d, skid_valid_d;
  logic [W-1:0] main_data, skid_data;
  main_load_e   main_sel;
  logic         skid_load;
  logic         accept, drain;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  // Next occupancy and load enables; flush overrides every other event.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    main_sel     = LOAD_NONE;
    skid_load    = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid) begin
      // Skid is never occupied while main is empty.
      if (accept) begin
        main_sel     = LOAD_IN;
        main_valid_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_valid) begin
        main_sel     = LOAD_SKID;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_sel = LOAD_IN;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Occupancy flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // Enable-gated payload storage; holds its value when nothing moves.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the payload store is reset too, so outputs read 0 during and after reset.
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      unique case (main_sel)
        LOAD_IN:   main_data <= in_data;
        LOAD_SKID: main_data <= skid_data;
        default:   ;
      endcase
      if (skid_load) skid_data <= in_data;
    end
  end

endmodule

// File: rtl/id_ex_elastic_stage.sv
// Decode->execute elastic pipeline stage: skid-buffered payload, control
// gating on empty slots and a saturating downstream-stall counter.
module id_ex_elastic_stage
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [VLEN-1:0]     imm_in,
  input  logic [VLEN-1:0]     read_data1_in,
  input  logic [VLEN-1:0]     read_data2_in,
  input  logic [ALU_OP_W-1:0] alu_op_in,
  input  logic [REG_W-1:0]    rs1_in,
  input  logic [REG_W-1:0]    rs2_in,
  input  logic [REG_W-1:0]    rd_in,
  input  logic                regwrite_in,
  input  logic                is_ai_in,
  input  logic [AI_OP_W-1:0]  ai_opcode_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pc_out,
  output logic [VLEN-1:0]     imm_out,
  output logic [VLEN-1:0]     read_data1_out,
  output logic [VLEN-1:0]     read_data2_out,
  output logic [ALU_OP_W-1:0] alu_op_out,
  output logic [REG_W-1:0]    rs1_out,
  output logic [REG_W-1:0]    rs2_out,
  output logic [REG_W-1:0]    rd_out,
  output logic                regwrite_out,
  output logic                is_ai_out,
  output logic [AI_OP_W-1:0]  ai_opcode_out,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_ex_payload_t in_pl, out_pl;

  assign in_pl = '{
    pc:        pc_in,
    imm:       imm_in,
    rd1:       read_data1_in,
    rd2:       read_data2_in,
    alu_op:    alu_op_in,
    rs1:       rs1_in,
    rs2:       rs2_in,
    rd:        rd_in,
    regwrite:  regwrite_in,
    is_ai:     is_ai_in,
    ai_opcode: ai_opcode_in
  };

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign pc_out         = out_pl.pc;
  assign imm_out        = out_pl.imm;
  assign read_data1_out = out_pl.rd1;
  assign read_data2_out = out_pl.rd2;
  assign alu_op_out     = out_pl.alu_op;
  assign rs1_out        = out_pl.rs1;
  assign rs2_out        = out_pl.rs2;
  assign rd_out         = out_pl.rd;
  assign ai_opcode_out  = out_pl.ai_opcode;

  // Side-effecting controls must never fire from an empty slot (e.g. stale
  // data left behind by a flush), so they are qualified by out_valid.
  assign regwrite_out = out_pl.regwrite & out_valid;
  assign is_ai_out    = out_pl.is_ai & out_valid;

  // Count cycles where a beat is offered but downstream refuses it; sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && stall_cycles != CNT_MAX) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_stage.sv
// Self-checking bench for id_ex_elastic_stage: reset, a directed vector
// table (streaming, backpressure, flush), stall saturation and a random
// valid/ready/flush run against a FIFO scoreboard.
module tb_id_ex_elastic_stage;
  import id_ex_pkg::*;

  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [XLEN-1:0]     pc_in = '0;
  logic [VLEN-1:0]     imm_in = '0;
  logic [VLEN-1:0]     read_data1_in = '0;
  logic [VLEN-1:0]     read_data2_in = '0;
  logic [ALU_OP_W-1:0] alu_op_in = '0;
  logic [REG_W-1:0]    rs1_in = '0;
  logic [REG_W-1:0]    rs2_in = '0;
  logic [REG_W-1:0]    rd_in = '0;
  logic                regwrite_in = 1'b0;
  logic                is_ai_in = 1'b0;
  logic [AI_OP_W-1:0]  ai_opcode_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [XLEN-1:0]     pc_out;
  logic [VLEN-1:0]     imm_out;
  logic [VLEN-1:0]     read_data1_out;
  logic [VLEN-1:0]     read_data2_out;
  logic [ALU_OP_W-1:0] alu_op_out;
  logic [REG_W-1:0]    rs1_out;
  logic [REG_W-1:0]    rs2_out;
  logic [REG_W-1:0]    rd_out;
  logic                regwrite_out;
  logic                is_ai_out;
  logic [AI_OP_W-1:0]  ai_opcode_out;
  logic [CNT_W-1:0]    stall_cycles;

  id_ex_payload_t out_pl;

  int checks   = 0;
  int failures = 0;

  id_ex_elastic_stage #(
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pc_in          (pc_in),
    .imm_in         (imm_in),
    .read_data1_in  (read_data1_in),
    .read_data2_in  (read_data2_in),
    .alu_op_in      (alu_op_in),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .rd_in          (rd_in),
    .regwrite_in    (regwrite_in),
    .is_ai_in       (is_ai_in),
    .ai_opcode_in   (ai_opcode_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc_out         (pc_out),
    .imm_out        (imm_out),
    .read_data1_out (read_data1_out),
    .read_data2_out (read_data2_out),
    .alu_op_out     (alu_op_out),
    .rs1_out        (rs1_out),
    .rs2_out        (rs2_out),
    .rd_out         (rd_out),
    .regwrite_out   (regwrite_out),
    .is_ai_out      (is_ai_out),
    .ai_opcode_out  (ai_opcode_out),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  assign out_pl = {pc_out, imm_out, read_data1_out, read_data2_out, alu_op_out,
                   rs1_out, rs2_out, rd_out, regwrite_out, is_ai_out, ai_opcode_out};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic iv, input logic orr, input logic fl, input id_ex_payload_t p);
    in_valid      = iv;
    out_ready     = orr;
    flush         = fl;
    pc_in         = p.pc;
    imm_in        = p.imm;
    read_data1_in = p.rd1;
    read_data2_in = p.rd2;
    alu_op_in     = p.alu_op;
    rs1_in        = p.rs1;
    rs2_in        = p.rs2;
    rd_in         = p.rd;
    regwrite_in   = p.regwrite;
    is_ai_in      = p.is_ai;
    ai_opcode_in  = p.ai_opcode;
  endtask

  function automatic id_ex_payload_t make_pl(input logic [31:0] pc, input logic rw, input logic ai);
    id_ex_payload_t p;
    p.pc        = pc;
    p.imm       = {pc, ~pc, pc ^ 32'h5a5a_5a5a, pc + 32'd1};
    p.rd1       = {4{pc ^ 32'hffff_0000}};
    p.rd2       = {4{pc + 32'h1000}};
    p.alu_op    = pc[5:2];
    p.rs1       = pc[6:2];
    p.rs2       = pc[7:3];
    p.rd        = pc[4:0] ^ 5'h15;
    p.regwrite  = rw;
    p.is_ai     = ai;
    p.ai_opcode = pc[4:2];
    return p;
  endfunction

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, make_pl(32'h0, 1'b0, 1'b0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic        iv, orr, fl;
    logic [31:0] pc;
    logic        rw, ai;
    logic        e_ov, e_ir;
    logic [31:0] e_pc;
    logic        e_rw, e_ai;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, orr, fl, input logic [31:0] pc, input logic rw, ai,
                     input logic e_ov, e_ir, input logic [31:0] e_pc, input logic e_rw, e_ai);
    vec_t v;
    v = '{iv, orr, fl, pc, rw, ai, e_ov, e_ir, e_pc, e_rw, e_ai};
    vecs.push_back(v);
  endtask

  id_ex_payload_t sb[$];

  initial begin
    // ---------------- reset mid-stream ----------------
    do_reset();
    apply(1'b1, 1'b0, 1'b0, make_pl(32'hA0, 1'b1, 1'b1));
    @(posedge clk); #1;
    apply(1'b1, 1'b0, 1'b0, make_pl(32'hA4, 1'b1, 1'b1));
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    check("pre_reset_out_valid", out_valid, 1'b1);
    check("pre_reset_in_ready", in_ready, 1'b0);
    check("pre_reset_stall", stall_cycles, 4'd2);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_imm_out", imm_out, 128'h0);
    check("rst_regwrite_out", regwrite_out, 1'b0);
    check("rst_stall", stall_cycles, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);

    // ---------------- directed vector table ----------------
    //   iv orr fl  pc      rw ai   e_ov e_ir e_pc    e_rw e_ai
    for (int i = 0; i < 8; i++)
      add(1, 1, 0, 32'(i * 4), 0, 0, (i != 0), 1, 32'(i * 4 - 4), 0, 0);
    add(0, 1, 0, 32'h00, 0, 0,  1, 1, 32'h1C, 0, 0);
    add(0, 0, 0, 32'h00, 0, 0,  0, 1, 32'h00, 0, 0);
    // backpressure
    add(1, 0, 0, 32'h40, 0, 0,  0, 1, 32'h00, 0, 0);
    add(1, 0, 0, 32'h44, 0, 0,  1, 1, 32'h40, 0, 0);
    add(1, 0, 0, 32'h48, 0, 0,  1, 0, 32'h40, 0, 0);
    add(0, 1, 0, 32'h00, 0, 0,  1, 0, 32'h40, 0, 0);
    add(0, 1, 0, 32'h00, 0, 0,  1, 1, 32'h44, 0, 0);
    add(0, 0, 0, 32'h00, 0, 0,  0, 1, 32'h00, 0, 0);
    // flush with both entries full
    add(1, 0, 0, 32'h50, 1, 0,  0, 1, 32'h00, 0, 0);
    add(1, 0, 0, 32'h54, 1, 0,  1, 1, 32'h50, 1, 0);
    add(1, 0, 1, 32'h58, 1, 0,  1, 0, 32'h50, 1, 0);
    add(0, 0, 0, 32'h00, 0, 0,  0, 1, 32'h00, 0, 0);
    // beat accepted in the flush cycle is discarded
    add(1, 1, 1, 32'h60, 1, 0,  0, 1, 32'h00, 0, 0);
    add(0, 1, 0, 32'h00, 0, 0,  0, 1, 32'h00, 0, 0);
    // drain during flush completes, concurrent accept is discarded
    add(1, 1, 0, 32'h64, 1, 1,  0, 1, 32'h00, 0, 0);
    add(1, 1, 1, 32'h68, 1, 1,  1, 1, 32'h64, 1, 1);
    add(0, 0, 0, 32'h00, 0, 0,  0, 1, 32'h00, 0, 0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].iv, vecs[i].orr, vecs[i].fl, make_pl(vecs[i].pc, vecs[i].rw, vecs[i].ai));
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("v%0d_regwrite_out", i), regwrite_out, vecs[i].e_rw);
      check($sformatf("v%0d_is_ai_out", i), is_ai_out, vecs[i].e_ai);
      if (vecs[i].e_ov)
        check($sformatf("v%0d_payload", i), out_pl, make_pl(vecs[i].e_pc, vecs[i].e_rw, vecs[i].e_ai));
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check("table_stall_cycles", stall_cycles, 4'd4);

    // ---------------- stall counter saturation ----------------
    do_reset();
    apply(1'b1, 1'b0, 1'b0, make_pl(32'h80, 1'b0, 1'b0));
    @(posedge clk); #1;
    idle();
    repeat (19) @(posedge clk);
    #1;
    check("stall_sat_20", stall_cycles, 4'd15);
    repeat (5) @(posedge clk);
    #1;
    check("stall_sat_hold", stall_cycles, 4'd15);
    check("stall_sat_out_valid", out_valid, 1'b1);

    // ---------------- random valid/ready/flush vs FIFO scoreboard ----------------
    do_reset();
    begin
      logic [31:0]    seq;
      logic           iv, orr, fl;
      id_ex_payload_t p;
      seq = 32'h1000;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        iv  = ($urandom_range(0, 3) != 0);
        orr = ($urandom_range(0, 2) != 0);
        fl  = ($urandom_range(0, 31) == 0);
        p.pc        = seq;
        p.imm       = {$urandom, $urandom, $urandom, $urandom};
        p.rd1       = {$urandom, $urandom, $urandom, $urandom};
        p.rd2       = {$urandom, $urandom, $urandom, $urandom};
        p.alu_op    = ALU_OP_W'($urandom);
        p.rs1       = REG_W'($urandom);
        p.rs2       = REG_W'($urandom);
        p.rd        = REG_W'($urandom);
        p.regwrite  = 1'($urandom);
        p.is_ai     = 1'($urandom);
        p.ai_opcode = AI_OP_W'($urandom);
        apply(iv, orr, fl, p);
        @(negedge clk);
        check("rnd_out_valid", out_valid, sb.size() != 0);
        check("rnd_in_ready", in_ready, sb.size() < 2);
        if (!out_valid) begin
          check("rnd_is_ai_gated", is_ai_out, 1'b0);
          check("rnd_regwrite_gated", regwrite_out, 1'b0);
        end
        if (out_valid && orr && sb.size() != 0) begin
          check("rnd_payload_order", out_pl, sb[0]);
          void'(sb.pop_front());
        end
        if (fl) sb.delete();
        else if (iv && in_ready) begin
          sb.push_back(p);
          seq = seq + 32'd1;
        end
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
